// File: rtl/wb_pkg.sv
// Shared widths, default depth and the queued-write entry type for the register write-back queue.
// No logic; imported by reg_wb_queue and wb_entry_fifo.
package wb_pkg;

    localparam int REG_IDX_W        = 4;
    localparam int DATA_W           = 16;
    localparam int WB_DEPTH_DEFAULT = 4;

    typedef struct packed {
        logic [REG_IDX_W-1:0] reg_idx;
        logic [DATA_W-1:0]    data;
    } wb_entry_t;

endpackage

// File: rtl/wb_entry_fifo.sv
// Circular FIFO of write-back entries; head is combinational, push lands on the next edge.
// Push when full is honoured only alongside a pop; clear wins over push and pop.
module wb_entry_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH_DEFAULT
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clear,
    input  logic                        push,
    input  wb_entry_t                   push_entry,
    input  logic                        pop,
    output wb_entry_t                   head,
    output wb_entry_t [DEPTH-1:0]       entries,
    output logic [$clog2(DEPTH)-1:0]    rd_ptr,
    output logic [$clog2(DEPTH):0]      count,
    output logic                        full,
    output logic                        empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wb_entry_t [DEPTH-1:0] mem;
    logic [PTR_W-1:0]      wr_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr];
    assign entries = mem;

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/reg_wb_queue.sv
// Register-file write-back queue, load over ALU; 1-cycle latency, no bypass; optional WB_R0_ZERO_EN drops R0 writes.
// Backpressure: ready falls on flush, reset, or full while wb_hold; a full queue still accepts when it pops.
module reg_wb_queue #(
    parameter int DEPTH = wb_pkg::WB_DEPTH_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ld_valid,
    input  logic [3:0]               ld_reg,
    input  logic [15:0]              ld_data,
    output logic                     ld_ready,
    input  logic                     alu_valid,
    input  logic [3:0]               alu_reg,
    input  logic [15:0]              alu_data,
    output logic                     alu_ready,
    input  logic                     wb_hold,
    input  logic                     flush,
    output logic [3:0]               DstReg,
    output logic [15:0]              DstData,
    output logic                     WriteReg,
    input  logic [3:0]               SrcReg1,
    input  logic [3:0]               SrcReg2,
    output logic                     Src1Pending,
    output logic                     Src2Pending,
    output logic [$clog2(DEPTH):0]   count
);

    import wb_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wb_entry_t             push_entry;
    wb_entry_t             head;
    wb_entry_t [DEPTH-1:0] entries;
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      slot_ofs;
    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  enq;
    logic                  pop;

    assign ld_ready  = rst_n & ~flush & (~full | ~wb_hold);
    assign alu_ready = ld_ready & ~ld_valid;
    assign push      = (ld_valid & ld_ready) | (alu_valid & alu_ready);

    always_comb begin
        push_entry = '0;
        if (ld_valid) begin
            push_entry.reg_idx = ld_reg;
            push_entry.data    = ld_data;
        end else begin
            push_entry.reg_idx = alu_reg;
            push_entry.data    = alu_data;
        end
    end

`ifdef WB_R0_ZERO_EN
    // R0 is hardwired zero: handshake completes but nothing is stored.
    assign enq = push & (push_entry.reg_idx != '0);
`else
    assign enq = push;
`endif

    assign pop      = rst_n & ~empty & ~wb_hold & ~flush;
    assign WriteReg = pop;
    assign DstReg   = head.reg_idx;
    assign DstData  = head.data;

    wb_entry_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (flush),
        .push       (enq),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (head),
        .entries    (entries),
        .rd_ptr     (rd_ptr),
        .count      (count),
        .full       (full),
        .empty      (empty)
    );

    // A slot is live when its distance from the head is below the occupancy.
    always_comb begin
        Src1Pending = 1'b0;
        Src2Pending = 1'b0;
        slot_ofs    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot_ofs = PTR_W'(i) - rd_ptr;
            if (CNT_W'(slot_ofs) < count) begin
                if (entries[i].reg_idx == SrcReg1) Src1Pending = 1'b1;
                if (entries[i].reg_idx == SrcReg2) Src2Pending = 1'b1;
            end
        end
    end

endmodule

// File: doc/reg_wb_queue.md
REG_WB_QUEUE -- requirements
Module: reg_wb_queue

Interface
REQ-001 SHALL have parameter: DEPTH, 4, number of queued register writes; power of two, 2..8.
REQ-002 SHALL have ports, clock and reset first:
- clk  in  1  sole clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- ld_valid  in  1  load-result write request.
- ld_reg  in  4  load destination register.
- ld_data  in  16  load result.
- ld_ready  out  1  load request accepted this cycle when high with ld_valid.
- alu_valid  in  1  ALU-result write request.
- alu_reg  in  4  ALU destination register.
- alu_data  in  16  ALU result.
- alu_ready  out  1  ALU request accepted this cycle when high with alu_valid.
- wb_hold  in  1  register-file write port unavailable this cycle.
- flush  in  1  discard all queued writes.
- DstReg  out  4  register-file write index.
- DstData  out  16  register-file write data.
- WriteReg  out  1  register-file write enable.
- SrcReg1  in  4  decode-stage read index 1.
- SrcReg2  in  4  decode-stage read index 2.
- Src1Pending  out  1  SrcReg1 has a queued, unwritten write.
- Src2Pending  out  1  SrcReg2 has a queued, unwritten write.
- count  out  log2(DEPTH)+1  current occupancy.

Function
REQ-003 SHALL hold up to DEPTH entries {reg, data} in FIFO order and accept at most one enqueue per cycle.
REQ-004 SHALL give the load source priority: ld_ready = ~flush & (~full | ~wb_hold); alu_ready = ld_ready & ~ld_valid.
REQ-005 SHALL drive WriteReg = ~empty & ~wb_hold & ~flush, with DstReg/DstData taken combinationally from the head entry.
REQ-006 SHALL pop the head on every cycle in which WriteReg is high.
REQ-007 SHALL have a latency of 1 cycle: a request accepted into an empty queue in cycle N appears on WriteReg in cycle N+1. There is no same-cycle bypass.
REQ-008 SHALL support push and pop in the same cycle, including when full; count is then unchanged.
REQ-009 SHALL keep count, entries and pointers unchanged while wb_hold is high and no push occurs.
REQ-010 SHALL set SrcNPending high iff SrcRegN matches the reg field of any valid entry, the head included, using current-cycle state. SrcNPending is combinational.
REQ-011 SHALL, on flush, empty the queue at the next edge, write nothing to the register file, and accept no request that cycle; flush wins over push and pop.
REQ-012 SHALL wrap the read/write pointers modulo DEPTH. full = (count == DEPTH); empty = (count == 0).
REQ-013 SHALL retain ordering when the same register is queued twice, so the later write lands last.

Reset
REQ-014 SHALL, on a clk edge with rst_n low:
- clear count, pointers and all entries to 0;
- force WriteReg=0, DstReg=0, DstData=0, Src1Pending=0, Src2Pending=0;
- drop any in-flight request.
REQ-015 SHALL drive ld_ready=0 and alu_ready=0 while rst_n is low.

Configuration
REQ-016 SHALL, when macro WB_R0_ZERO_EN is defined, accept requests to register 0 (ready asserted as normal) without enqueuing them. Register 0 is then never pending and never written.
REQ-017 SHALL, without WB_R0_ZERO_EN, treat register 0 exactly like registers 1-15.

Structure
REQ-018 SHALL place the following in shared package wb_pkg:
- REG_IDX_W=4, DATA_W=16, WB_DEPTH_DEFAULT=4;
- typedef wb_entry_t {reg, data}.
REQ-019 SHALL instantiate one sub-module, wb_entry_fifo, covering storage, pointers and count. Arbitration, hold/flush gating and the pending compare stay in reg_wb_queue.

Verification
REQ-020 Idle pass-through: ld {R3, 0x1234} accepted in cycle 0 -> cycle 1 WriteReg=1, DstReg=3, DstData=0x1234; cycle 2 WriteReg=0.
REQ-021 Priority: ld {R1, 0xAAAA} and alu {R2, 0x5555} both valid -> ld_ready=1, alu_ready=0; ALU accepted the next cycle; writes occur in order R1, then R2.
REQ-022 Full under hold: wb_hold=1 with 4 pushes -> count=4. Fifth push with hold still high -> ld_ready=0. Drop hold and push the same cycle -> accepted, count stays 4.
REQ-023 Pending: queue {R5, R7} with SrcReg1=7, SrcReg2=6 -> Src1Pending=1, Src2Pending=0; after R7 is written -> Src1Pending=0.
REQ-024 Flush/reset mid-operation: 3 entries queued, flush=1 with ld_valid=1 -> no write, ld_ready=0, count=0 next cycle. Same sequence with rst_n=0 -> all outputs 0.
REQ-025 WB_R0_ZERO_EN: alu {R0, 0xFFFF} -> alu_ready=1, count stays 0, WriteReg never asserts. Without the macro -> R0 is written at the next cycle.
